// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: MSB-first bit-serial magnitude compare with cascade seeds
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             e_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] sa, sb;
  logic [IW-1:0] idx;
  logic e, g, sm, ai, bi, e_next, g_next, last;
  // one compare slice on the current MSB plus next-state and status decode
  always_comb begin
    ai = sa[WIDTH-1];
    bi = sb[WIDTH-1];
    e_next = e & ~(ai ^ bi);
    g_next = (sm && idx == IW'(WIDTH-1)) ? g | (e & ~ai & bi) : g | (e & ai & ~bi);
    last = (idx == '0) || (EARLY_EXIT && !e_next);
    state_next = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  // operand shifters, running e/g and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      e <= 1'b0;
      g <= 1'b0;
      sm <= 1'b0;
      idx <= '0;
      {eq, gt, lt} <= 3'b000;
    end else if (state == IDLE && start) begin
      sa <= a;
      sb <= b;
      e <= e_in;
      g <= g_in;
      sm <= signed_mode;
      idx <= IW'(WIDTH-1);
    end else if (state == RUN) begin
      sa <= sa << 1;
      sb <= sb << 1;
      e <= e_next;
      g <= g_next;
      idx <= idx - 1'b1;
      if (last) {eq, gt, lt} <= {e_next, g_next, ~e_next & ~g_next};
    end
  end
endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator: directed table plus corner sequences and sweeps over four configurations
module tb_serial_mag_comparator;
  logic clk = 0, rst = 1, start = 0, signed_mode = 0, e_in = 1, g_in = 0;
  logic [15:0] a = '0, b = '0;
  logic [3:0] busy, done, eq, gt, lt;
  int checks = 0, errors = 0;
  int lat[4];
  int wid[4] = '{8, 8, 4, 16};
  bit ee[4] = '{1, 0, 1, 0};
  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1)) d0 (.clk(clk), .rst(rst), .start(start), .a(a[7:0]), .b(b[7:0]),
    .signed_mode(signed_mode), .e_in(e_in), .g_in(g_in), .busy(busy[0]), .done(done[0]), .eq(eq[0]), .gt(gt[0]), .lt(lt[0]));
  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(0)) d1 (.clk(clk), .rst(rst), .start(start), .a(a[7:0]), .b(b[7:0]),
    .signed_mode(signed_mode), .e_in(e_in), .g_in(g_in), .busy(busy[1]), .done(done[1]), .eq(eq[1]), .gt(gt[1]), .lt(lt[1]));
  serial_mag_comparator #(.WIDTH(4), .EARLY_EXIT(1)) d2 (.clk(clk), .rst(rst), .start(start), .a(a[3:0]), .b(b[3:0]),
    .signed_mode(signed_mode), .e_in(e_in), .g_in(g_in), .busy(busy[2]), .done(done[2]), .eq(eq[2]), .gt(gt[2]), .lt(lt[2]));
  serial_mag_comparator #(.WIDTH(16), .EARLY_EXIT(0)) d3 (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .e_in(e_in), .g_in(g_in), .busy(busy[3]), .done(done[3]), .eq(eq[3]), .gt(gt[3]), .lt(lt[3]));

  typedef struct {
    logic [7:0] a, b;
    logic sm, ei, gi;
    logic [2:0] res;
    int lat;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic sm, input logic ei, input logic gi);
    longint x, y;
    if (!ei) return gi ? 3'b010 : 3'b001;
    x = longint'(av) & ((longint'(1) << w) - 1);
    y = longint'(bv) & ((longint'(1) << w) - 1);
    if (sm && av[w-1]) x -= longint'(1) << w;
    if (sm && bv[w-1]) y -= longint'(1) << w;
    return x == y ? 3'b100 : x > y ? 3'b010 : 3'b001;
  endfunction

  function automatic int lat_model(input int w, input bit early, input logic [15:0] av, input logic [15:0] bv, input logic ei);
    if (!early) return w + 1;
    if (!ei) return 2;
    for (int k = w - 1; k >= 0; k--) if (av[k] != bv[k]) return w - k + 1;
    return w + 1;
  endfunction

  task automatic run_cmp(input logic [15:0] av, input logic [15:0] bv, input logic sm, input logic ei, input logic gi, input int pulse_at);
    int n = 0;
    @(negedge clk);
    while (busy != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    a = av; b = bv; signed_mode = sm; e_in = ei; g_in = gi; start = 1;
    @(posedge clk);
    #1;
    start = 0; a = ~av; b = ~bv; signed_mode = ~sm; e_in = 0; g_in = ~gi;
    chk("busy_after_accept", busy, 4'hF);
    foreach (lat[i]) lat[i] = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (done[i] && lat[i] == 0) lat[i] = k + 1;
      if (k == pulse_at) start = 1;
      else if (k == pulse_at + 1) start = 0;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
    end
    for (int i = 0; i < 4; i++) chk($sformatf("timeout_dut%0d", i), int'(lat[i] != 0), 1);
  endtask

  initial begin
    int ndone, t[$], cyc;
    tbl[0] = '{8'h5A, 8'h5A, 0, 1, 0, 3'b100, 9};
    tbl[1] = '{8'h80, 8'h7F, 0, 1, 0, 3'b010, 2};
    tbl[2] = '{8'h12, 8'h13, 0, 1, 0, 3'b001, 9};
    tbl[3] = '{8'hFF, 8'h01, 1, 1, 0, 3'b001, 2};
    tbl[4] = '{8'h7F, 8'h80, 1, 1, 0, 3'b010, 2};
    tbl[5] = '{8'hFE, 8'hFF, 1, 1, 0, 3'b001, 9};
    tbl[6] = '{8'h00, 8'hFF, 0, 0, 1, 3'b010, 2};
    tbl[7] = '{8'hFF, 8'h00, 0, 0, 0, 3'b001, 2};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, eq, gt, lt}, 0);
    @(negedge clk) rst = 0;
    foreach (tbl[i]) begin
      run_cmp({8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].sm, tbl[i].ei, tbl[i].gi, 0);
      chk($sformatf("tbl%0d_res_ee1", i), {eq[0], gt[0], lt[0]}, tbl[i].res);
      chk($sformatf("tbl%0d_lat_ee1", i), lat[0], tbl[i].lat);
      chk($sformatf("tbl%0d_res_ee0", i), {eq[1], gt[1], lt[1]}, tbl[i].res);
      chk($sformatf("tbl%0d_lat_ee0", i), lat[1], 9);
    end
    @(negedge clk);
    while (busy != 0) @(negedge clk);
    a = 16'h1111; b = 16'h1111; signed_mode = 0; e_in = 1; g_in = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1;
    #1 chk("abort_outputs", {busy, done, eq, gt, lt}, 0);
    @(negedge clk) rst = 0;
    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done != 0) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_cmp(16'h0012, 16'h0013, 0, 1, 0, 0);
    chk("after_abort_res", {eq[0], gt[0], lt[0]}, 3'b001);
    chk("after_abort_lat", lat[0], 9);
    run_cmp(16'h0012, 16'h0013, 0, 1, 0, 3);
    chk("pulse_res_ee1", {eq[0], gt[0], lt[0]}, 3'b001);
    chk("pulse_lat_ee1", lat[0], 9);
    chk("pulse_res_ee0", {eq[1], gt[1], lt[1]}, 3'b001);
    chk("pulse_lat_ee0", lat[1], 9);
    @(negedge clk);
    while (busy != 0) @(negedge clk);
    a = 16'h005A; b = 16'h005A; signed_mode = 0; e_in = 1; g_in = 0; start = 1;
    cyc = 0;
    repeat (35) begin
      @(posedge clk);
      #1 cyc++;
      if (done[1]) t.push_back(cyc);
    end
    start = 0;
    chk("held_count", t.size(), 3);
    if (t.size() >= 3) begin
      chk("held_first", t[0], 9);
      chk("held_period0", t[1] - t[0], 10);
      chk("held_period1", t[2] - t[1], 10);
    end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int s = 0; s < 2; s++) begin
          logic [15:0] av, bv;
          logic ei, gi;
          av = {$urandom_range(0, 16'hFFF), 4'(i)};
          bv = {$urandom_range(0, 16'hFFF), 4'(j)};
          if ($urandom_range(0, 1)) bv[15:4] = av[15:4];
          ei = $urandom_range(0, 7) != 0;
          gi = ei ? 1'b0 : 1'($urandom_range(0, 1));
          run_cmp(av, bv, 1'(s), ei, gi, 0);
          for (int d = 0; d < 4; d++) begin
            chk($sformatf("sweep_res_dut%0d a=%h b=%h s=%0d e=%0d g=%0d", d, av, bv, s, ei, gi), {eq[d], gt[d], lt[d]}, model(wid[d], av, bv, 1'(s), ei, gi));
            chk($sformatf("sweep_lat_dut%0d a=%h b=%h", d, av, bv), lat[d], lat_model(wid[d], ee[d], av, bv, ei));
          end
        end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
